// File: rtl/m72_pkg.sv
// Shared types and constants for the SDRAM read arbiter and its round-robin picker.
package m72_pkg;

  localparam int SDR_ADDR_W = 24;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_t;

  // Region bases, word addressed; only bits above the channel address width survive.
  localparam logic [SDR_ADDR_W-1:0] REGION_BG_A_BASE = 24'h100000;
  localparam logic [SDR_ADDR_W-1:0] REGION_BG_B_BASE = 24'h200000;
  localparam logic [SDR_ADDR_W-1:0] REGION_SPR_BASE  = 24'h340000;
  localparam logic [SDR_ADDR_W-1:0] REGION_MISC_BASE = 24'h0C0000;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first pending requester at or after i_rr_ptr, ascending with wrap.
module rr_pick
  import m72_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int PTR_W  = ptr_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_pending,
  input  logic [PTR_W-1:0]  i_rr_ptr,
  output logic [PTR_W-1:0]  o_grant,
  output logic              o_any_pending
);

  logic [2*NUM_CH-1:0] w_dbl;
  logic [NUM_CH-1:0]   w_rot;
  logic [PTR_W-1:0]    w_off;
  logic [PTR_W:0]      w_sum;

  // Doubling the vector turns the wrap-around search into a plain lowest-set-bit search.
  assign w_dbl         = {i_pending, i_pending};
  assign w_rot         = w_dbl[i_rr_ptr +: NUM_CH];
  assign o_any_pending = |i_pending;

  always_comb begin
    w_off = '0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_off = PTR_W'(j);
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, i_rr_ptr} + {1'b0, w_off};
    if (w_sum >= (PTR_W + 1)'(NUM_CH)) begin
      o_grant = PTR_W'(w_sum - (PTR_W + 1)'(NUM_CH));
    end else begin
      o_grant = w_sum[PTR_W-1:0];
    end
  end

endmodule

// File: rtl/sdram_rr_read_arbiter.sv
// N-channel round-robin read arbiter in front of a single SDRAM read port, one read in flight.
// Handshake: sdr_req is a one-cycle pulse per issue (re-pulsed on timeout); sdr_rdy is a one-cycle completion, ignored outside WAIT.
module sdram_rr_read_arbiter
  import m72_pkg::*;
#(
  parameter int                             NUM_CH     = 2,
  parameter int                             CH_ADDR_W  = 18,
  parameter int                             DATA_W     = 32,
  parameter logic [NUM_CH*SDR_ADDR_W-1:0]   BASE_ADDRS = {NUM_CH{24'h0}},
  parameter int                             TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH*CH_ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH-1:0]             ch_req,
  output logic [DATA_W-1:0]             ch_data,
  output logic [NUM_CH-1:0]             ch_rdy,
  output logic [NUM_CH-1:0]             overrun,
  output logic [SDR_ADDR_W-1:0]         sdr_addr,
  input  logic [DATA_W-1:0]             sdr_data,
  output logic                          sdr_req,
  input  logic                          sdr_rdy,
  output logic                          o_dbg_state
);

  localparam int PTR_W = ptr_width(NUM_CH);
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t              r_state;
  arb_state_t              w_state_next;
  logic [NUM_CH-1:0]       r_req_prev;
  logic [NUM_CH-1:0]       r_pending;
  logic [NUM_CH-1:0]       r_overrun;
  logic [SDR_ADDR_W-1:0]   r_addr [NUM_CH];
  logic [PTR_W-1:0]        r_rr_ptr;
  logic [PTR_W-1:0]        r_cur;
  logic [TMR_W-1:0]        r_timer;
  logic [SDR_ADDR_W-1:0]   r_sdr_addr;
  logic                    r_sdr_req;
  logic [DATA_W-1:0]       r_ch_data;
  logic [NUM_CH-1:0]       r_ch_rdy;

  logic [NUM_CH-1:0]       w_edge;
  logic [NUM_CH-1:0]       w_busy;
  logic [NUM_CH-1:0]       w_grant_oh;
  logic [SDR_ADDR_W-1:0]   w_full_addr [NUM_CH];
  logic [PTR_W-1:0]        w_grant;
  logic [PTR_W-1:0]        w_rr_next;
  logic                    w_any;
  logic                    w_issue;
  logic                    w_complete;
  logic                    w_retry;

  assign w_edge = ch_req & ~r_req_prev;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    if (CH_ADDR_W >= SDR_ADDR_W) begin : g_wide
      assign w_full_addr[i] = ch_addr[i*CH_ADDR_W +: SDR_ADDR_W];
    end else begin : g_narrow
      assign w_full_addr[i] = {BASE_ADDRS[i*SDR_ADDR_W + CH_ADDR_W +: SDR_ADDR_W - CH_ADDR_W],
                               ch_addr[i*CH_ADDR_W +: CH_ADDR_W]};
    end
    // A channel counts as busy while queued or while its read is the one in flight.
    assign w_busy[i]     = r_pending[i] | ((r_state == ST_WAIT) && (r_cur == PTR_W'(i)));
    assign w_grant_oh[i] = w_issue && (w_grant == PTR_W'(i));
  end

  rr_pick #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_rr_pick (
    .i_pending     (r_pending),
    .i_rr_ptr      (r_rr_ptr),
    .o_grant       (w_grant),
    .o_any_pending (w_any)
  );

  assign w_rr_next = (w_grant == PTR_W'(NUM_CH - 1)) ? '0 : w_grant + PTR_W'(1);

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_complete   = 1'b0;
    w_retry      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_issue      = 1'b1;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sdr_rdy) begin
          w_complete   = 1'b1;
          w_state_next = ST_IDLE;
        end else if ((TIMEOUT > 0) && (r_timer == TMR_W'(TIMEOUT))) begin
          w_retry = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_prev <= '0;
      r_pending  <= '0;
      r_overrun  <= '0;
      r_rr_ptr   <= '0;
      r_cur      <= '0;
      r_timer    <= '0;
      r_sdr_addr <= '0;
      r_sdr_req  <= 1'b0;
      r_ch_data  <= '0;
      r_ch_rdy   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_addr[i] <= '0;
      end
    end else begin
      r_req_prev <= ch_req;
      // A same-cycle edge on the granted channel survives the clear and stays queued.
      r_pending  <= (r_pending & ~w_grant_oh) | w_edge;
      r_overrun  <= r_overrun | (w_edge & w_busy);
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_edge[i]) begin
          r_addr[i] <= w_full_addr[i];
        end
      end
      r_sdr_req <= w_issue | w_retry;
      r_ch_rdy  <= '0;
      if (w_issue) begin
        r_sdr_addr <= r_addr[w_grant];
        r_cur      <= w_grant;
        r_rr_ptr   <= w_rr_next;
        r_timer    <= '0;
      end else if (r_state == ST_WAIT) begin
        if (w_retry) begin
          r_timer <= '0;
        end else if ((TIMEOUT > 0) && !sdr_rdy) begin
          r_timer <= r_timer + TMR_W'(1);
        end
      end
      if (w_complete) begin
        r_ch_data <= sdr_data;
        r_ch_rdy  <= NUM_CH'(1) << r_cur;
      end
    end
  end

  assign ch_data     = r_ch_data;
  assign ch_rdy      = r_ch_rdy;
  assign overrun     = r_overrun;
  assign sdr_addr    = r_sdr_addr;
  assign sdr_req     = r_sdr_req;
  assign o_dbg_state = r_state;

endmodule
